// File: rtl/mdu.sv
// mdu -- multi-cycle multiply/divide unit for the EX stage of the P5 mips core.
//
// Owns the HI/LO architectural registers. When idle, an operation is launched
// by start: the full result is computed from the operands present at the launch
// edge and parked in hi_tmp/lo_tmp. A down-counter then models the unit's
// latency, and the parked result is written to HI/LO on the last busy edge.
//
// Handshake: start/mthi/mtlo are accepted only while busy=0. start has priority
// over a simultaneous move. While busy=1, every request is dropped. The hazard
// unit is expected to hold requests off using stall_req.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (and madd/maddu), >= 1
//   DIV_CYCLES   busy cycles for div/divu, >= 1
//
// Optional feature macro: MDU_MADD_EN
//   When defined, op 4 = madd (signed) and op 5 = maddu (unsigned) are enabled.
//   Each accumulates into {hi,lo} using the HI/LO values present at launch.
//   When undefined, ops 4/5 are reserved and ignored like ops 6/7.
//
// Ports:
//   clk        core clock, rising edge
//   reset      asynchronous active-low reset
//   start      launch the operation selected by op (idle only)
//   op         0 mult, 1 multu, 2 div, 3 divu, (4 madd, 5 maddu), others reserved
//   mthi/mtlo  write a into HI/LO (idle, no start)
//   a, b       rs / rt operands
//   busy       operation in flight (registered)
//   stall_req  busy | start (combinational)
//   hi, lo     HI/LO registers
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] count;
  logic [31:0]   hi_tmp;
  logic [31:0]   lo_tmp;
  logic          skip_wb;  // divide by zero: leave HI/LO untouched at completion

  // ---------------------------------------------------------------------------
  // Result datapath
  // ---------------------------------------------------------------------------
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes. This avoids the 0x80000000 / -1 overflow
  // corner: the magnitude of 0x80000000 is still 0x80000000 when treated as
  // unsigned, so the quotient lands on 0x80000000 with a remainder of 0.
  // A zero divisor is replaced by 1 so the divider never sees /0. That result
  // is then discarded by skip_wb.
  assign a_neg  = a[31];
  assign b_neg  = b[31];
  assign a_mag  = a_neg ? (32'd0 - a) : a;
  assign b_mag  = (b == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - b) : b);
  assign q_mag  = a_mag / b_mag;
  assign r_mag  = a_mag % b_mag;
  assign q_s    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s    = a_neg ? (32'd0 - r_mag) : r_mag;
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;

  // ---------------------------------------------------------------------------
  // Op decode
  // ---------------------------------------------------------------------------
  logic          op_valid;
  logic [63:0]   op_result;
  logic [CW-1:0] op_cycles;
  logic          op_div0;

  always_comb begin
    op_valid  = 1'b0;
    op_result = 64'd0;
    op_cycles = CW'(MULT_CYCLES);
    op_div0   = 1'b0;
    case (op)
      3'd0: begin
        op_valid  = 1'b1;
        op_result = prod_s;
      end
      3'd1: begin
        op_valid  = 1'b1;
        op_result = prod_u;
      end
      3'd2: begin
        op_valid  = 1'b1;
        op_result = {r_s, q_s};
        op_cycles = CW'(DIV_CYCLES);
        op_div0   = (b == 32'd0);
      end
      3'd3: begin
        op_valid  = 1'b1;
        op_result = {r_u, q_u};
        op_cycles = CW'(DIV_CYCLES);
        op_div0   = (b == 32'd0);
      end
`ifdef MDU_MADD_EN
      3'd4: begin
        op_valid  = 1'b1;
        op_result = {hi, lo} + prod_s;
      end
      3'd5: begin
        op_valid  = 1'b1;
        op_result = {hi, lo} + prod_u;
      end
`endif
      default: begin
        op_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      count   <= '0;
      hi_tmp  <= 32'd0;
      lo_tmp  <= 32'd0;
      skip_wb <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (busy) begin
      // Requests arriving while busy are deliberately ignored.
      if (count == CW'(1)) begin
        busy  <= 1'b0;
        count <= '0;
        if (!skip_wb) begin
          hi <= hi_tmp;
          lo <= lo_tmp;
        end
      end else begin
        count <= count - CW'(1);
      end
    end else if (start) begin
      // start beats a simultaneous move; a reserved op is simply dropped.
      if (op_valid) begin
        busy    <= 1'b1;
        count   <= op_cycles;
        hi_tmp  <= op_result[63:32];
        lo_tmp  <= op_result[31:0];
        skip_wb <= op_div0;
      end
    end else begin
      if (mthi) hi <= a;
      if (mtlo) lo <= a;
    end
  end

  assign stall_req = busy | start;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- directed plus light random bench for mdu.
// Expected HI/LO are pushed to exp_q when an operation is launched. They are
// popped and compared when busy falls. A shadow copy of HI/LO (m_hi/m_lo)
// supplies the prior values needed for divide-by-zero and madd expectations.
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        mthi;
  logic        mtlo;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          checks;
  int          errors;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model and check helper
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] res;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    res = {m_hi, m_lo};
    case (o)
      3'd0: res = sx * sy;
      3'd1: res = {32'd0, x} * {32'd0, y};
      3'd2: if (y != 32'd0) begin
        q   = sx / sy;
        r   = sx % sy;
        res = {r[31:0], q[31:0]};
      end
      3'd3: if (y != 32'd0) res = {x % y, x / y};
      3'd4: res = {m_hi, m_lo} + 64'(sx * sy);
      3'd5: res = {m_hi, m_lo} + ({32'd0, x} * {32'd0, y});
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on negedge, outputs sampled on negedge)
  // ---------------------------------------------------------------------------
  task automatic do_move(input logic h, input logic l, input logic [31:0] v);
    @(negedge clk);
    mthi = h;
    mtlo = l;
    a    = v;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    check("move_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n, input logic mv);
    int cnt;
    logic [63:0] e;
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    mthi  = mv;
    mtlo  = mv;
    #1;
    check({tag, "_stall_launch"}, {62'd0, busy, stall_req}, 64'd1);
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    a     = $urandom;
    b     = $urandom;
    cnt   = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
    e = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, e);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic reserved_op(input string tag, input logic [2:0] o);
    @(negedge clk);
    op    = o;
    a     = 32'h1;
    b     = 32'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] e;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    a      = 32'd0;
    b      = 32'd0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;

    // Reset state
    #3;
    check("reset_state", {31'd0, busy, hi, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-divide discards the op and clears HI/LO immediately
    do_move(1'b1, 1'b1, 32'h5555_5555);
    @(negedge clk);
    op    = 3'd2;
    a     = 32'd100;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("async_reset", {31'd0, busy, hi, lo}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    run_op("div_7_2", 3'd2, 32'd7, 32'd2, DIV_N, 1'b0);
    check("div_7_2_const", {hi, lo}, {32'd1, 32'd3});

    // Multiply
    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, MULT_N, 1'b0);
    check("mult_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, MULT_N, 1'b0);
    check("multu_const", {hi, lo}, {32'h1, 32'hFFFF_FFFE});

    // Signed divide and overflow corner
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_N, 1'b0);
    check("div_neg_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 1'b0);
    check("div_ovf_const", {hi, lo}, {32'h0, 32'h8000_0000});
    run_op("divu", 3'd3, 32'hFFFF_FFF0, 32'd7, DIV_N, 1'b0);

    // Divide by zero keeps prior HI/LO
    do_move(1'b1, 1'b0, 32'h11);
    do_move(1'b0, 1'b1, 32'h22);
    run_op("divu_zero", 3'd3, 32'd5, 32'd0, DIV_N, 1'b0);
    check("divu_zero_const", {hi, lo}, {32'h11, 32'h22});
    run_op("div_zero", 3'd2, 32'hFFFF_FF00, 32'd0, DIV_N, 1'b0);

    // start beats a simultaneous move
    run_op("start_vs_move", 3'd0, 32'd6, 32'd7, MULT_N, 1'b1);
    check("start_vs_move_const", {hi, lo}, 64'd42);

    // Requests during busy are ignored; stall_req held high
    @(negedge clk);
    op    = 3'd1;
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    #1;
    check("ign_stall_launch", {62'd0, busy, stall_req}, 64'd1);
    exp_q.push_back(64'd15);
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    while (busy === 1'b1 && cnt < 200) begin
      check("ign_stall_busy", {63'd0, stall_req}, 64'd1);
      cnt++;
      if (cnt == 1) begin
        start = 1'b1;
        op    = 3'd2;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        a     = 32'hDEAD_BEEF;
        b     = 32'd0;
      end else begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
      end
      @(negedge clk);
    end
    check("ign_busy_cycles", 64'(cnt), 64'(MULT_N));
    e = exp_q.pop_front();
    check("ign_hilo", {hi, lo}, e);
    m_hi = e[63:32];
    m_lo = e[31:0];
    check("idle_stall", {62'd0, busy, stall_req}, 64'd0);

    // Optional multiply-accumulate, or reserved ops 4/5
    do_move(1'b1, 1'b0, 32'h0);
    do_move(1'b0, 1'b1, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", 3'd5, 32'd1, 32'd1, MULT_N, 1'b0);
    check("maddu_const", {hi, lo}, {32'h1, 32'h0});
    run_op("madd", 3'd4, 32'hFFFF_FFFF, 32'd3, MULT_N, 1'b0);
`else
    reserved_op("rsv_op5", 3'd5);
    reserved_op("rsv_op4", 3'd4);
`endif
    reserved_op("rsv_op7", 3'd7);

    // Random mult/div traffic
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      run_op("rand", ro, ra, rb, (ro < 3'd2) ? MULT_N : DIV_N, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
